result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 150 +++++++++++++++
 tb/tb_result_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// rtl/result_collector.sv - drains solver RAM banks in pixel order into a ready/valid pixel stream
// Bank/address generated by wrap counters; returned words go through a 2-entry FIFO.
module result_collector #(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_PIXELS  = 1024
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        solvers_done_i,
  output logic [5:0]  rd_solver_id_o,
  output logic [9:0]  rd_addr_o,
  input  logic [7:0]  rd_data_in_i,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [7:0]  pix_data_o,
  output logic [15:0] pix_index_o,
  output logic        pix_last_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_STREAM = 2'd2;
  localparam logic [1:0]  S_DRAIN  = 2'd3;
  localparam logic [5:0]  LAST_ID  = 6'(NUM_SOLVERS - 1);
  localparam logic [16:0] NPIX     = 17'(NUM_PIXELS);
  localparam logic [15:0] LAST_IDX = 16'(NUM_PIXELS - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  id_q, id_d, rd_id_q, rd_id_d;
  logic [9:0]  addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [16:0] issued_q, issued_d;
  logic        inflight_q;
  logic [7:0]  head_q, head_d, tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic        frame_done_q, frame_done_d;
  logic        pop, push, room, issue;

  // A pixel leaving this cycle frees its slot, so steady state issues one read per cycle.
  assign pop   = (count_q != 2'd0) && pix_ready_i;
  assign push  = inflight_q;
  assign room  = (3'({1'b0, count_q}) - 3'(pop) + 3'(inflight_q)) < 3'd2;
  assign issue = (state_q == S_STREAM) && room && (issued_q < NPIX);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    issued_d     = issued_q;
    rd_id_d      = rd_id_q;
    rd_addr_d    = rd_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = 2'(count_q + 2'(push) - 2'(pop));
    idx_d        = 16'(idx_q + 16'(pop));
    frame_done_d = 1'b0;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = rd_data_in_i;
        else                 tail_d = rd_data_in_i;
      end
      2'b01: head_d = tail_q;
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = rd_data_in_i;
        end else begin
          head_d = tail_q;
          tail_d = rd_data_in_i;
        end
      end
      default: ;
    endcase

    if (issue) begin
      rd_id_d   = id_q;
      rd_addr_d = addr_q;
      issued_d  = 17'(issued_q + 17'd1);
      if (id_q == LAST_ID) begin
        id_d   = 6'd0;
        addr_d = 10'(addr_q + 10'd1);
      end else begin
        id_d = 6'(id_q + 6'd1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_WAIT;
          id_d     = 6'd0;
          addr_d   = 10'd0;
          issued_d = 17'd0;
          idx_d    = 16'd0;
        end
      end
      S_WAIT:   if (solvers_done_i) state_d = S_STREAM;
      S_STREAM: if (issue && (issued_q == NPIX - 17'd1)) state_d = S_DRAIN;
      default: begin
        if (pop && (idx_q == LAST_IDX)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      id_q         <= 6'd0;
      addr_q       <= 10'd0;
      issued_q     <= 17'd0;
      rd_id_q      <= 6'd0;
      rd_addr_q    <= 10'd0;
      inflight_q   <= 1'b0;
      head_q       <= 8'd0;
      tail_q       <= 8'd0;
      count_q      <= 2'd0;
      idx_q        <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      rd_id_q      <= rd_id_d;
      rd_addr_q    <= rd_addr_d;
      inflight_q   <= issue;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_solver_id_o = issue ? id_q : rd_id_q;
  assign rd_addr_o      = issue ? addr_q : rd_addr_q;
  assign pix_valid_o    = (count_q != 2'd0);
  assign pix_data_o     = head_q;
  assign pix_index_o    = idx_q;
  assign pix_last_o     = pix_valid_o && (idx_q == LAST_IDX);
  assign busy_o         = (state_q != S_IDLE);
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - self-checking bench for result_collector
// Three instances (4x16, 3x7, 1x1) share clock and reset; each bank RAM returns word = NS*addr + id.
module tb_result_collector;

  localparam int NS[3] = '{4, 3, 1};
  localparam int NP[3] = '{16, 7, 1};

  logic        clk = 1'b0;
  logic        rstn;
  logic        start[3], sdone[3], ready[3];
  logic [5:0]  rid[3];
  logic [9:0]  raddr[3];
  logic [7:0]  rdata[3];
  logic        valid[3], plast[3], busy[3], fd[3];
  logic [7:0]  pdata[3];
  logic [15:0] pidx[3];

  int checks = 0;
  int errors = 0;
  logic [7:0] acc_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    result_collector #(.NUM_SOLVERS(NS[g]), .NUM_PIXELS(NP[g])) u_dut (
      .clock_i(clk), .reset_ni(rstn), .start_i(start[g]), .solvers_done_i(sdone[g]),
      .rd_solver_id_o(rid[g]), .rd_addr_o(raddr[g]), .rd_data_in_i(rdata[g]),
      .pix_valid_o(valid[g]), .pix_ready_i(ready[g]), .pix_data_o(pdata[g]),
      .pix_index_o(pidx[g]), .pix_last_o(plast[g]), .busy_o(busy[g]), .frame_done_o(fd[g])
    );
  end

  // Banked RAM model: one-cycle read latency.
  always @(posedge clk)
    for (int d = 0; d < 3; d++) rdata[d] <= 8'(int'(rid[d]) + NS[d] * int'(raddr[d]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one frame on instance d and scores every accepted pixel against k = 0..NP-1.
  task automatic run_frame(input int d, input bit rnd, input int wait_cyc);
    int k, fdn, cyc, first_acc, last_acc, fd_cyc;
    bit stalled, did_start, wait_ok;
    logic [7:0] sd;
    logic [15:0] si;
    logic sl;
    logic [5:0] hid;
    logic [9:0] had;
    acc_q.delete();
    @(negedge clk);
    sdone[d] = (wait_cyc == 0);
    start[d] = 1'b1;
    hid = rid[d];
    had = raddr[d];
    @(negedge clk);
    start[d] = 1'b0;
    ready[d] = 1'b1;
    if (wait_cyc > 0) begin
      wait_ok = 1'b1;
      for (int i = 0; i < wait_cyc; i++) begin
        if (busy[d] !== 1'b1 || valid[d] !== 1'b0 || rid[d] !== hid || raddr[d] !== had) wait_ok = 1'b0;
        @(negedge clk);
      end
      check("wait_idle_no_reads", 32'(wait_ok), 32'd1);
      sdone[d] = 1'b1;
    end
    k = 0; fdn = 0; cyc = 0; first_acc = -1; last_acc = -1; fd_cyc = -100;
    stalled = 1'b0; did_start = 1'b0;
    sd = '0; si = '0; sl = 1'b0;
    while (cyc < 400 && !(fdn > 0 && cyc > fd_cyc + 3)) begin
      if (fd[d] === 1'b1) begin
        fdn++;
        if (fdn == 1) fd_cyc = cyc;
      end
      if (stalled) begin
        check("stall_valid", 32'(valid[d]), 32'd1);
        check("stall_stable", {pidx[d], pdata[d], 7'd0, plast[d]}, {si, sd, 7'd0, sl});
      end
      ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid[d] === 1'b1 && ready[d]) begin
        check("pix_index", 32'(pidx[d]), 32'(k));
        check("pix_data", 32'(pdata[d]), 32'(k % 256));
        check("pix_last", 32'(plast[d]), 32'(k == NP[d] - 1));
        acc_q.push_back(pdata[d]);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        k++;
      end
      stalled = (valid[d] === 1'b1) && !ready[d];
      sd = pdata[d]; si = pidx[d]; sl = plast[d];
      if (rnd) begin
        if (k >= 2) sdone[d] = 1'b0;
        if (k == 3 && !did_start) begin
          start[d] = 1'b1;
          did_start = 1'b1;
        end else begin
          start[d] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    check("pixel_count", 32'(k), 32'(NP[d]));
    check("frame_done_count", 32'(fdn), 32'd1);
    check("frame_done_timing", 32'(fd_cyc), 32'(last_acc + 1));
    check("idle_after_frame", {30'd0, busy[d], valid[d]}, 32'd0);
    if (!rnd) begin
      check("first_pixel_latency", 32'(first_acc), 32'd3);
      check("full_throughput", 32'(last_acc - first_acc), 32'(NP[d] - 1));
    end
  endtask

  typedef struct {
    logic        valid;
    logic [15:0] idx;
    logic [7:0]  data;
    logic        last;
    logic        busy;
    logic        fd;
  } vec_t;

  typedef struct {
    int id;
    int addr;
  } rd_t;

  vec_t tbl[22];
  rd_t  order[7];
  int   n, t;

  initial begin
    for (int c = 0; c < 22; c++) begin
      tbl[c].valid = (c >= 3 && c <= 18);
      tbl[c].idx   = 16'(c - 3);
      tbl[c].data  = 8'(c - 3);
      tbl[c].last  = (c == 18);
      tbl[c].busy  = (c <= 18);
      tbl[c].fd    = (c == 19);
    end
    order = '{'{0,0}, '{1,0}, '{2,0}, '{0,1}, '{1,1}, '{2,1}, '{0,2}};

    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; sdone[d] = 1'b0; ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_flags", {28'd0, valid[d], plast[d], busy[d], fd[d]}, 32'd0);
      check("reset_data", {pidx[d], pdata[d], 8'd0}, 32'd0);
      check("reset_rd", {16'd0, rid[d], raddr[d]}, 32'd0);
    end
    rstn = 1'b1;

    // Full-throughput frame on 4x16 compared cycle by cycle against the vector table.
    @(negedge clk);
    sdone[0] = 1'b1; ready[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int c = 0; c < 22; c++) begin
      check("tbl_valid", 32'(valid[0]), 32'(tbl[c].valid));
      check("tbl_last", 32'(plast[0]), 32'(tbl[c].last));
      check("tbl_busy", 32'(busy[0]), 32'(tbl[c].busy));
      check("tbl_frame_done", 32'(fd[0]), 32'(tbl[c].fd));
      if (tbl[c].valid) begin
        check("tbl_index", 32'(pidx[0]), 32'(tbl[c].idx));
        check("tbl_data", 32'(pdata[0]), 32'(tbl[c].data));
      end
      @(negedge clk);
    end

    run_frame(0, 1'b0, 20);
    run_frame(0, 1'b1, 0);

    // Mid-frame reset after five accepted pixels.
    @(negedge clk);
    sdone[0] = 1'b1; ready[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0; t = 0;
    while (n < 5 && t < 50) begin
      if (valid[0] === 1'b1) n++;
      @(negedge clk);
      t++;
    end
    check("accepted_before_reset", 32'(n), 32'd5);
    rstn = 1'b0;
    #1;
    check("abort_flags", {28'd0, valid[0], plast[0], busy[0], fd[0]}, 32'd0);
    check("abort_data", {pidx[0], pdata[0], 8'd0}, 32'd0);
    check("abort_rd", {16'd0, rid[0], raddr[0]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_frame_done", 32'(fd[0]), 32'd0);
    end
    rstn = 1'b1;
    run_frame(0, 1'b0, 0);

    run_frame(1, 1'b1, 0);
    check("order_len", 32'(acc_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < acc_q.size(); i++) begin
      check("order_id", 32'(int'(acc_q[i]) % 3), 32'(order[i].id));
      check("order_addr", 32'(int'(acc_q[i]) / 3), 32'(order[i].addr));
    end

    run_frame(2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
